trdb_trace_buffer: RTL

Capture buffer directly downstream of the trace packet aligner. It accepts the 32-bit packet words produced by the trace compression pipeline, one per cycle, and stores them in a circular FIFO. A host-side reader drains the FIFO through a simple request/response port. The block tracks the fill level, sticky overflow, a count of dropped words, and a level-threshold interrupt.

---
 rtl/trdb_trace_buffer.sv | 116 +++++++++++
 1 files changed

// File: rtl/trdb_trace_buffer.sv
// Circular capture FIFO for aligned trace packet words, drained by a host reader.
// Tracks occupancy, sticky overflow, a saturating dropped-word count and a level interrupt.
module trdb_trace_buffer #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned THRESH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [XLEN-1:0]              word_i,
    input  logic                         word_valid_i,
    input  logic                         read_req_i,
    output logic [XLEN-1:0]              read_data_o,
    output logic                         read_valid_o,
    input  logic                         flush_i,
    input  logic                         clear_ovf_i,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         overflow_o,
    output logic [15:0]                  lost_cnt_o,
    output logic                         irq_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH+1);

    logic [XLEN-1:0] mem [DEPTH];

    logic [AW-1:0]   wp_reg, wp_next;
    logic [AW-1:0]   rp_reg, rp_next;
    logic [LW-1:0]   level_reg, level_next;
    logic            ovf_reg, ovf_next;
    logic [15:0]     lost_reg, lost_next, lost_base;
    logic            irq_reg, irq_next;
    logic [XLEN-1:0] rdata_reg;
    logic            rvalid_reg;
    logic            empty, full, rd, wr, drop;

    always_comb begin
        empty      = (level_reg == '0);
        full       = (level_reg == LW'(DEPTH));
        // A flush discards any same-cycle read, write or drop.
        rd         = read_req_i && !empty && !flush_i;
        wr         = word_valid_i && (!full || rd) && !flush_i;
        drop       = word_valid_i && full && !rd && !flush_i;

        wp_next    = wp_reg;
        rp_next    = rp_reg;
        level_next = level_reg;
        ovf_next   = ovf_reg;
        lost_base  = lost_reg;
        lost_next  = lost_reg;

        if (flush_i) begin
            wp_next    = '0;
            rp_next    = '0;
            level_next = '0;
            ovf_next   = 1'b0;
            lost_next  = '0;
        end else begin
            if (wr) wp_next = wp_reg + AW'(1);
            if (rd) rp_next = rp_reg + AW'(1);
            if (wr && !rd)      level_next = level_reg + LW'(1);
            else if (rd && !wr) level_next = level_reg - LW'(1);

            // A drop in the same cycle as a clear is counted after the clear.
            if (clear_ovf_i) begin
                lost_base = '0;
                ovf_next  = 1'b0;
            end
            lost_next = lost_base;
            if (drop) begin
                ovf_next  = 1'b1;
                lost_next = (lost_base == 16'hFFFF) ? lost_base : lost_base + 16'd1;
            end
        end

        irq_next = (level_next >= LW'(THRESH)) || ovf_next;
    end

    always_ff @(posedge clk_i) begin
        if (wr) mem[wp_reg] <= word_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_reg     <= '0;
            rp_reg     <= '0;
            level_reg  <= '0;
            ovf_reg    <= 1'b0;
            lost_reg   <= '0;
            irq_reg    <= 1'b0;
            rvalid_reg <= 1'b0;
        end else begin
            wp_reg     <= wp_next;
            rp_reg     <= rp_next;
            level_reg  <= level_next;
            ovf_reg    <= ovf_next;
            lost_reg   <= lost_next;
            irq_reg    <= irq_next;
            rvalid_reg <= rd;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)  rdata_reg <= '0;
        else if (rd)  rdata_reg <= mem[rp_reg];
    end

    assign read_data_o  = rdata_reg;
    assign read_valid_o = rvalid_reg;
    assign level_o      = level_reg;
    assign overflow_o   = ovf_reg;
    assign lost_cnt_o   = lost_reg;
    assign irq_o        = irq_reg;

endmodule
